updown_mod_counter: RTL and testbench
=====================================

// Module: updown_mod_counter
// PURPOSE
//  Parametrised up/down modulo counter; next generation of the team's 4-bit ripple counter.
//  Adds width/modulus generics, direction control, synchronous load/clear, count enable,
//  wrap or saturate mode, and a cascadable terminal-count output.
//  Fully synchronous (single clk domain) apart from reset; used as timebase and event counter.
// PARAMETERS
//  WIDTH     4    counter width in bits (>=1)
//  MODULUS   16   count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH
//  SATURATE  0    0 = wrap at range ends; 1 = hold at range ends and set ovf
// PORTS
//  clk       in   1      rising-edge clock
//  reset     in   1      asynchronous, active-high reset
//  en        in   1      count enable
//  up        in   1      direction: 1 = increment, 0 = decrement
//  load      in   1      synchronous load of load_val
//  load_val  in   WIDTH  value for load
//  clear     in   1      synchronous clear to 0
//  q         out  WIDTH  current count (registered)
//  tc        out  1      terminal count, combinational: en & (up ? q==MODULUS-1 : q==0)
//  wrap      out  1      registered 1-cycle pulse: count wrapped (SATURATE=0) or was blocked (SATURATE=1)
//  ovf       out  1      sticky: set on any wrap/block event; cleared by clear, load or reset
// BEHAVIOUR
//  - Reset (async, reset=1): q=0, wrap=0, ovf=0 immediately; held while reset=1. tc follows q/en.
//  - Priority per rising edge: clear > load > en > hold.
//  - clear: q<=0, wrap<=0, ovf<=0, regardless of en/load.
//  - load: q<=load_val if load_val<MODULUS, else q<=MODULUS-1 (clamp); wrap<=0, ovf<=0.
//  - en & up: q<MODULUS-1 -> q+1; q==MODULUS-1 -> 0 (SATURATE=0) or hold (SATURATE=1).
//  - en & !up: q>0 -> q-1; q==0 -> MODULUS-1 (SATURATE=0) or hold (SATURATE=1).
//  - Range-end event (en & tc): wrap<=1 for exactly one cycle, ovf<=1 (sticky).
//  - No event or en=0: q holds, wrap<=0, ovf holds.
//  - Latency: q reflects a control input one clock after the sampling edge; tc is same-cycle.
//  - Arithmetic in WIDTH+1 bits internally; q never leaves 0..MODULUS-1, including
//    MODULUS=2**WIDTH (natural wrap) and direction change on the same edge as wrap.
//  - Cascading: stage N+1 en = stage N tc; all stages share clk and reset (no ripple clocking).
//  - Reset asserted mid-count: outputs zero asynchronously; counting resumes from 0 on the
//    first edge after deassertion if en=1.
// STRUCTURE
//  - Package counter_pkg: localparams DIR_UP=1'b1, DIR_DOWN=1'b0, MODE_WRAP=0, MODE_SAT=1,
//    and function clamp_mod(val, modulus) shared with the load path and the bench model.
//  - Sub-module mod_counter_step (combinational): inputs q, up, SATURATE/MODULUS params;
//    outputs q_next, at_end. Top holds registers, priority mux, wrap/ovf flags, tc.
// TESTING
//  1. Reset/basic up, WIDTH=4 MODULUS=16: reset 15 ns then en=1 up=1 -> q 0,1..15,0;
//     tc=1 at q=15; wrap pulses one cycle after that edge; ovf=1 thereafter.
//  2. Modulo down, MODULUS=10: load 3, en=1 up=0 -> q 3,2,1,0,9,8; tc=1 while q=0;
//     wrap one cycle after the 0->9 edge.
//  3. Saturate, SATURATE=1 MODULUS=10: load 8, up=1 -> q 8,9,9,9; wrap pulses each blocked
//     edge; ovf=1; clear -> q=0 ovf=0 next edge.
//  4. Priority: clear=1 load=1 load_val=5 en=1 same edge -> q=0; load=1 en=1 -> q=5;
//     load_val=12 with MODULUS=10 -> q=9.
//  5. Async reset mid-operation: counting at q=7, assert reset between edges -> q=0 before next
//     edge; hold 10 ns; release -> q=1 one edge later.
//  6. Cascade: two instances MODULUS=10, second en = first tc -> 00..99 sequence, 99 -> 00,
//     second-stage wrap pulse once per 100 clocks.

Source files
------------

// File: rtl/updown_mod_counter_pkg.sv
// Shared constants and the load-value clamp for the up/down modulo counter family.
// The clamp is written with 32-bit operands so any counter width up to 32 can use it.
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam int   MODE_WRAP = 0;
  localparam int   MODE_SAT  = 1;

  function automatic logic [31:0] clamp_mod(input logic [31:0] val, input logic [31:0] modulus);
    logic [31:0] res;
    if (val < modulus) begin
      res = val;
    end else begin
      res = modulus - 32'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/updown_mod_counter_step.sv
// Combinational next-count logic: one step up or down within 0..MODULUS-1,
// flagging the range end so the parent can raise wrap/ovf.
module mod_counter_step
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up,
  output logic [WIDTH-1:0] q_next,
  output logic             at_end
);

  // One extra bit keeps MODULUS == 2**WIDTH representable without overflow.
  localparam logic [WIDTH:0] LAST = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0] ONE  = (WIDTH+1)'(1);

  logic [WIDTH:0] q_ext_s;
  logic [WIDTH:0] sum_s;

  // Step in the requested direction, wrapping or holding at the range ends.
  always_comb begin
    q_ext_s = {1'b0, q};
    at_end  = 1'b0;
    sum_s   = q_ext_s;
    if (up == DIR_UP) begin
      at_end = (q_ext_s == LAST);
      if (at_end) begin
        sum_s = (SATURATE == MODE_SAT) ? q_ext_s : '0;
      end else begin
        sum_s = q_ext_s + ONE;
      end
    end else begin
      at_end = (q_ext_s == '0);
      if (at_end) begin
        sum_s = (SATURATE == MODE_SAT) ? q_ext_s : LAST;
      end else begin
        sum_s = q_ext_s - ONE;
      end
    end
    q_next = sum_s[WIDTH-1:0];
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with load/clear, wrap or saturate mode,
// a cascadable combinational terminal count and registered wrap/ovf flags.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] step_next_s;
  logic             at_end_s;
  logic [WIDTH-1:0] load_clamp_s;

  mod_counter_step #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS),
    .SATURATE(SATURATE)
  ) u_step (
    .q     (cnt_q),
    .up    (up),
    .q_next(step_next_s),
    .at_end(at_end_s)
  );

  assign load_clamp_s = WIDTH'(clamp_mod(32'(load_val), 32'(MODULUS)));

  // Priority: clear > load > en > hold; a range-end step raises wrap and ovf.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    ovf_d  = ovf_q;
    if (clear) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (load) begin
      cnt_d = load_clamp_s;
      ovf_d = 1'b0;
    end else if (en) begin
      cnt_d = step_next_s;
      if (at_end_s) begin
        wrap_d = 1'b1;
        ovf_d  = 1'b1;
      end else begin
        wrap_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign q    = cnt_q;
  assign wrap = wrap_q;
  assign ovf  = ovf_q;
  assign tc   = en & at_end_s;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a monitor pops and
// compares them against four counter configurations sharing one set of controls.
module tb_updown_mod_counter;

  logic       clk;
  logic       reset;
  logic       en, up, load, clear;
  logic [3:0] load_val;

  logic [3:0] q0, q1, q2, q3l, q3h;
  logic       tc0, tc1, tc2, tc3l, tc3h;
  logic       wr0, wr1, wr2, wr3l, wr3h;
  logic       ov0, ov1, ov2, ov3l, ov3h;

  typedef struct {
    int   dut;
    int   q;
    logic tc;
    logic wrap;
    logic ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   n_push = 0;

  updown_mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .clear(clear), .q(q0), .tc(tc0), .wrap(wr0), .ovf(ov0));

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_m10 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .clear(clear), .q(q1), .tc(tc1), .wrap(wr1), .ovf(ov1));

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_sat (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .clear(clear), .q(q2), .tc(tc2), .wrap(wr2), .ovf(ov2));

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_lo (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .clear(clear), .q(q3l), .tc(tc3l), .wrap(wr3l), .ovf(ov3l));

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_hi (
    .clk(clk), .reset(reset), .en(tc3l), .up(up), .load(load), .load_val(load_val),
    .clear(clear), .q(q3h), .tc(tc3h), .wrap(wr3h), .ovf(ov3h));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d of %0d vectors checked", n_vec, n_push);
    $fatal(1, "watchdog");
  end

  task automatic push(input int d, input int qv, input logic t, input logic w, input logic o);
    exp_t e;
    e.dut  = d;
    e.q    = qv;
    e.tc   = t;
    e.wrap = w;
    e.ovf  = o;
    sb_q.push_back(e);
    n_push++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic l, input logic [3:0] lv,
                       input logic e, input logic u);
    clear    = c;
    load     = l;
    load_val = lv;
    en       = e;
    up       = u;
  endtask

  // Monitor: checks every queued expectation shortly after each falling edge or reset rise.
  initial begin
    exp_t e;
    int   aq;
    logic at, aw, ao;
    forever begin
      @(negedge clk or posedge reset);
      #1;
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        case (e.dut)
          0: begin aq = int'(q0); at = tc0; aw = wr0; ao = ov0; end
          1: begin aq = int'(q1); at = tc1; aw = wr1; ao = ov1; end
          2: begin aq = int'(q2); at = tc2; aw = wr2; ao = ov2; end
          3: begin aq = int'(q3h) * 10 + int'(q3l); at = tc3h; aw = wr3h; ao = ov3h; end
          default: begin aq = -1; at = 1'bx; aw = 1'bx; ao = 1'bx; end
        endcase
        n_vec++;
        if (aq !== e.q || at !== e.tc || aw !== e.wrap || ao !== e.ovf) begin
          n_miss++;
          $display("FAIL vec%0d dut%0d @%0t: got q=%0d tc=%b wrap=%b ovf=%b, expected q=%0d tc=%b wrap=%b ovf=%b",
                   n_vec, e.dut, $time, aq, at, aw, ao, e.q, e.tc, e.wrap, e.ovf);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    #1;
    push(0, 0, 1'b0, 1'b0, 1'b0);
    push(1, 0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Basic up count, modulus 16
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) begin
      push(0, i, (i == 15), 1'b0, 1'b0);
      tick();
    end
    push(0, 0, 1'b0, 1'b1, 1'b1);
    tick();
    push(0, 1, 1'b0, 1'b0, 1'b1);
    tick();

    // Modulo-10 down count through zero
    drive(1'b0, 1'b1, 4'd3, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    push(1, 3, 1'b0, 1'b0, 1'b0); tick();
    push(1, 2, 1'b0, 1'b0, 1'b0); tick();
    push(1, 1, 1'b0, 1'b0, 1'b0); tick();
    push(1, 0, 1'b1, 1'b0, 1'b0); tick();
    push(1, 9, 1'b0, 1'b1, 1'b1); tick();
    push(1, 8, 1'b0, 1'b0, 1'b1); tick();

    // Saturating up count, then clear
    drive(1'b0, 1'b1, 4'd8, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    push(2, 8, 1'b0, 1'b0, 1'b0); tick();
    push(2, 9, 1'b1, 1'b0, 1'b0); tick();
    push(2, 9, 1'b1, 1'b1, 1'b1); tick();
    drive(1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
    push(2, 9, 1'b1, 1'b1, 1'b1); tick();
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    push(2, 0, 1'b0, 1'b0, 1'b0); tick();

    // Priority and load clamp
    drive(1'b1, 1'b1, 4'd5, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b1, 4'd5, 1'b1, 1'b1);
    push(1, 0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b1, 4'd12, 1'b1, 1'b1);
    push(1, 5, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    push(1, 9, 1'b0, 1'b0, 1'b0);
    push(0, 12, 1'b0, 1'b0, 1'b0);
    tick();

    // Asynchronous reset between edges
    drive(1'b0, 1'b1, 4'd6, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    push(0, 6, 1'b0, 1'b0, 1'b0); tick();
    push(0, 7, 1'b0, 1'b0, 1'b0);
    #6;
    push(0, 0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #10;
    reset = 1'b0;
    tick();
    push(0, 1, 1'b0, 1'b0, 1'b0); tick();

    // Two-stage decade cascade, 00..99 twice
    drive(1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 100; i++) begin
        push(3, i, (i == 99), (p == 1 && i == 0), (p == 1));
        tick();
      end
    end
    push(3, 0, 1'b0, 1'b1, 1'b1);
    tick();

    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    repeat (3) tick();
    if (sb_q.size() != 0 || n_vec != n_push) begin
      n_miss++;
      $display("FAIL drain: checked %0d vectors, required %0d (pending %0d)", n_vec, n_push, sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
